// File: rtl/axi_bridge_pkg.sv
// axi_bridge_pkg: shared AR payload, arbiter FSM states and default requester IDs
package axi_bridge_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
  } ar_beat_t;
  typedef enum logic {IDLE, ISSUE} arb_state_t;
  localparam logic [3:0] INST_ID = 4'h0;
  localparam logic [3:0] DATA_ID = 4'h1;
endpackage

// File: rtl/axi_rd_arbiter_outst_counter.sv
// outst_counter: outstanding-read counter that saturates at both ends and flags when LIMIT is reached
module outst_counter #(
  parameter int LIMIT = 4,
  parameter int W = 4
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic inc,
  input  logic dec,
  output logic full
);
  logic [W-1:0] cnt;
  assign full = cnt >= W'(LIMIT);
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) cnt <= '0;
    else if (inc & ~dec & ~full) cnt <= cnt + 1'b1;
    else if (dec & ~inc & |cnt) cnt <= cnt - 1'b1;
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin AR arbiter for two read requesters with rid-steered R channel; AXI_RD_ARB_STATS_EN adds grant counters and an unknown-rid flag
module axi_rd_arbiter
  import axi_bridge_pkg::*;
#(
  parameter logic [3:0] M0_ID = INST_ID,
  parameter logic [3:0] M1_ID = DATA_ID,
  parameter int MAX_OUTST = 4,
  parameter int CNT_W = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        m0_arvalid,
  input  logic [31:0] m0_araddr,
  input  logic [2:0]  m0_arsize,
  output logic        m0_arready,
  input  logic        m1_arvalid,
  input  logic [31:0] m1_araddr,
  input  logic [2:0]  m1_arsize,
  output logic        m1_arready,
  output logic        arvalid,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [3:0]  rid,
  input  logic        rlast,
  output logic        rready,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  output logic        m1_rvalid,
  input  logic        m1_rready
`ifdef AXI_RD_ARB_STATS_EN
  ,
  output logic [31:0] m0_grant_cnt,
  output logic [31:0] m1_grant_cnt,
  output logic        err_unknown_rid
`endif
);
  arb_state_t state;
  ar_beat_t   ar;
  logic       ptr;
  logic       full0, full1, e0, e1, hs, hit0, hit1, beat_done;
  assign e0 = m0_arvalid & ~full0;
  assign e1 = m1_arvalid & ~full1;
  // ptr=0 favours M0 on a tie
  assign m0_arready = (state == IDLE) & e0 & (~e1 | ~ptr);
  assign m1_arready = (state == IDLE) & e1 & (~e0 | ptr);
  assign hs = arvalid & arready;
  assign {arid, araddr, arsize} = ar;
  assign hit0 = rid == M0_ID;
  assign hit1 = rid == M1_ID;
  assign m0_rvalid = rvalid & hit0;
  assign m1_rvalid = rvalid & hit1;
  assign rready = hit0 ? m0_rready : hit1 ? m1_rready : 1'b1;
  assign beat_done = rvalid & rready & rlast;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state   <= IDLE;
      arvalid <= 1'b0;
      ar      <= '0;
      ptr     <= 1'b0;
    end else if (state == IDLE) begin
      if (m0_arready | m1_arready) begin
        state   <= ISSUE;
        arvalid <= 1'b1;
        ar      <= m0_arready ? ar_beat_t'{M0_ID, m0_araddr, m0_arsize}
                              : ar_beat_t'{M1_ID, m1_araddr, m1_arsize};
        ptr     <= m0_arready;
      end
    end else if (arready) begin
      state   <= IDLE;
      arvalid <= 1'b0;
    end
  outst_counter #(.LIMIT(MAX_OUTST), .W(CNT_W)) u_cnt0 (
    .aclk(aclk), .aresetn(aresetn),
    .inc(hs & (arid == M0_ID)), .dec(beat_done & hit0), .full(full0)
  );
  outst_counter #(.LIMIT(MAX_OUTST), .W(CNT_W)) u_cnt1 (
    .aclk(aclk), .aresetn(aresetn),
    .inc(hs & (arid == M1_ID)), .dec(beat_done & hit1), .full(full1)
  );
`ifdef AXI_RD_ARB_STATS_EN
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      m0_grant_cnt    <= '0;
      m1_grant_cnt    <= '0;
      err_unknown_rid <= 1'b0;
    end else begin
      if (hs & (arid == M0_ID)) m0_grant_cnt <= m0_grant_cnt + 1'b1;
      if (hs & (arid == M1_ID)) m1_grant_cnt <= m1_grant_cnt + 1'b1;
      if (rvalid & rready & ~hit0 & ~hit1) err_unknown_rid <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed plus randomized stimulus checked against a transaction-level model
module tb_axi_rd_arbiter;
  localparam int MAX = 4;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic m0_arvalid = 0, m1_arvalid = 0, arready = 0, rvalid = 0, rlast = 0, m0_rready = 0, m1_rready = 0;
  logic [31:0] m0_araddr = 0, m1_araddr = 0, araddr;
  logic [2:0] m0_arsize = 0, m1_arsize = 0, arsize;
  logic [3:0] rid = 0, arid;
  logic m0_arready, m1_arready, arvalid, rready, m0_rvalid, m1_rvalid;
`ifdef AXI_RD_ARB_STATS_EN
  logic [31:0] m0_grant_cnt, m1_grant_cnt;
  logic err_unknown_rid;
`endif
  always #5 aclk = ~aclk;
  axi_rd_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arsize(m0_arsize), .m0_arready(m0_arready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arsize(m1_arsize), .m1_arready(m1_arready),
    .arvalid(arvalid), .arid(arid), .araddr(araddr), .arsize(arsize), .arready(arready),
    .rvalid(rvalid), .rid(rid), .rlast(rlast), .rready(rready),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready)
`ifdef AXI_RD_ARB_STATS_EN
    , .m0_grant_cnt(m0_grant_cnt), .m1_grant_cnt(m1_grant_cnt), .err_unknown_rid(err_unknown_rid)
`endif
  );
  int checks = 0, errors = 0;
  bit busy;
  int pend, turn;
  int outst [2];
  int unsigned grants [2];
  bit err_seen;
  logic [31:0] p_addr;
  logic [2:0] p_size;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    busy = 0; pend = 0; turn = 0; outst = '{0, 0}; grants = '{0, 0}; err_seen = 0;
  endtask
  task automatic eval();
    bit e0, e1, rr_exp;
    int win, own;
    #1;
    e0 = m0_arvalid && outst[0] < MAX;
    e1 = m1_arvalid && outst[1] < MAX;
    win = -1;
    if (!busy) win = (e0 && e1) ? turn : e0 ? 0 : e1 ? 1 : -1;
    check("m0_arready", 32'(m0_arready), 32'(win == 0));
    check("m1_arready", 32'(m1_arready), 32'(win == 1));
    check("arvalid", 32'(arvalid), 32'(busy));
    if (busy) begin
      check("arid", 32'(arid), pend);
      check("araddr", araddr, p_addr);
      check("arsize", 32'(arsize), 32'(p_size));
    end
    own = (rid == 4'h0) ? 0 : (rid == 4'h1) ? 1 : -1;
    rr_exp = (own == 0) ? m0_rready : (own == 1) ? m1_rready : 1'b1;
    check("m0_rvalid", 32'(m0_rvalid), 32'(rvalid && own == 0));
    check("m1_rvalid", 32'(m1_rvalid), 32'(rvalid && own == 1));
    check("rready", 32'(rready), 32'(rr_exp));
`ifdef AXI_RD_ARB_STATS_EN
    check("m0_grant_cnt", m0_grant_cnt, grants[0]);
    check("m1_grant_cnt", m1_grant_cnt, grants[1]);
    check("err_unknown_rid", 32'(err_unknown_rid), 32'(err_seen));
`endif
    if (busy && arready) begin
      outst[pend]++;
      grants[pend]++;
      busy = 0;
    end
    if (rvalid && rr_exp && rlast && own >= 0 && outst[own] > 0) outst[own]--;
    if (rvalid && rr_exp && own < 0) err_seen = 1;
    if (win >= 0) begin
      busy = 1; pend = win; turn = 1 - win;
      p_addr = win ? m1_araddr : m0_araddr;
      p_size = win ? m1_arsize : m0_arsize;
    end
  endtask
  task automatic drive(input bit a0, a1, arr, rv, input logic [3:0] r_id, input bit rl, rr0, rr1);
    @(negedge aclk);
    m0_arvalid = a0; m1_arvalid = a1; arready = arr;
    m0_araddr = $urandom; m1_araddr = $urandom;
    m0_arsize = 3'($urandom_range(0, 7)); m1_arsize = 3'($urandom_range(0, 7));
    rvalid = rv; rid = r_id; rlast = rl; m0_rready = rr0; m1_rready = rr1;
    eval();
  endtask
  task automatic do_reset();
    #2 aresetn = 0;
    #1 check("rst_arvalid", 32'(arvalid), 32'd0);
    {m0_arvalid, m1_arvalid, arready, rvalid, rlast, m0_rready, m1_rready} = '0;
    model_reset();
    @(negedge aclk);
    aresetn = 1;
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge aclk);
    aresetn = 1;
    @(negedge aclk);
    m0_arvalid = 1; m0_araddr = 32'h1C000000; m0_arsize = 3'd2;
    eval();
    repeat (3) drive(0, 0, 0, 0, 4'h0, 0, 0, 0);
    drive(0, 0, 1, 0, 4'h0, 0, 0, 0);
    drive(0, 0, 0, 0, 4'h0, 0, 0, 0);
    repeat (8) drive(1, 1, 1, 0, 4'h0, 0, 0, 0);
    repeat (10) drive(0, 1, 1, 0, 4'h0, 0, 0, 0);
    repeat (6) drive(1, 1, 1, 0, 4'h0, 0, 0, 0);
    drive(0, 1, 1, 1, 4'h1, 1, 0, 1);
    repeat (3) drive(0, 1, 1, 0, 4'h0, 0, 0, 0);
    drive(0, 0, 0, 1, 4'h1, 0, 1, 0);
    drive(0, 0, 0, 1, 4'h1, 1, 0, 1);
    drive(0, 0, 0, 1, 4'h5, 1, 0, 0);
    drive(0, 0, 1, 1, 4'h0, 1, 1, 0);
    drive(1, 0, 0, 0, 4'h0, 0, 0, 0);
    drive(0, 0, 1, 1, 4'h0, 1, 1, 0);
    drive(1, 0, 0, 0, 4'h0, 0, 0, 0);
    drive(0, 0, 0, 0, 4'h0, 0, 0, 0);
    do_reset();
    drive(1, 1, 1, 0, 4'h0, 0, 0, 0);
    repeat (3) drive(0, 0, 1, 0, 4'h0, 0, 0, 0);
    for (int p = 0; p < 6; p++) begin
      int rv_pct = (p % 3 == 0) ? 5 : (p % 3 == 1) ? 40 : 80;
      for (int c = 0; c < 300; c++) begin
        int k = $urandom_range(0, 4);
        logic [3:0] r = (k < 2) ? 4'h0 : (k < 4) ? 4'h1 : 4'($urandom_range(2, 15));
        drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60,
              $urandom_range(0, 99) < rv_pct, r, $urandom_range(0, 1) == 1,
              $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70);
      end
      if (p == 3) do_reset();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
